// File: rtl/branch_resolve_queue.sv
// branch_resolve_queue: in-order queue of branch predictions that resolves outcomes, flags mispredicts with a flush, and updates the predictor.
module branch_resolve_queue #(
  parameter int DEPTH = 4,
  parameter int IDX_W = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pred_valid,
  input  logic             pred_dir,
  input  logic [IDX_W-1:0] pred_idx,
  output logic             pred_ready,
  input  logic             res_valid,
  input  logic             res_taken,
  output logic             upd_valid,
  output logic [IDX_W-1:0] upd_idx,
  output logic             upd_taken,
  output logic             mispredict,
  output logic             empty,
  output logic             full,
  output logic             res_err,
  output logic [CNT_W-1:0] total_cnt,
  output logic [CNT_W-1:0] miss_cnt
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] DCNT = (PW+1)'(DEPTH);
  typedef enum logic [1:0] {s_empty, s_partial, s_full} state_t;
  state_t state, state_nxt;
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [PW:0] count, count_nxt;
  logic dir_q [DEPTH];
  logic [IDX_W-1:0] idx_q [DEPTH];
  logic push, pop, miss;
  assign empty = state == s_empty;
  assign full = state == s_full;
  assign pred_ready = ~full;
  assign push = pred_valid & ~full;
  assign pop = res_valid & ~empty;
  assign miss = pop & (dir_q[rd_ptr] != res_taken);
  always_comb begin
    count_nxt = miss ? '0 : count + (PW+1)'(push) - (PW+1)'(pop);
    state_nxt = count_nxt == '0 ? s_empty : count_nxt == DCNT ? s_full : s_partial;
  end
  always_ff @(posedge clk) begin
    if (push && !miss) begin
      dir_q[wr_ptr] <= pred_dir;
      idx_q[wr_ptr] <= pred_idx;
    end
  end
  // A mispredict squashes everything younger, including a same-cycle push.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= s_empty;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      upd_valid <= 1'b0;
      upd_idx <= '0;
      upd_taken <= 1'b0;
      mispredict <= 1'b0;
      res_err <= 1'b0;
      total_cnt <= '0;
      miss_cnt <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      if (miss) rd_ptr <= wr_ptr;
      else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop) rd_ptr <= rd_ptr + PW'(1);
      end
      upd_valid <= pop;
      mispredict <= miss;
      if (pop) begin
        upd_idx <= idx_q[rd_ptr];
        upd_taken <= res_taken;
      end
      if (res_valid && empty) res_err <= 1'b1;
      if (pop && ~&total_cnt) total_cnt <= total_cnt + CNT_W'(1);
      if (miss && ~&miss_cnt) miss_cnt <= miss_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_branch_resolve_queue.sv
// tb_branch_resolve_queue: directed checks of fill, in-order resolve, flush, error, saturation and reset.
module tb_branch_resolve_queue;
  logic clk = 0, rst = 1;
  logic pred_valid = 0, pred_dir = 0, res_valid = 0, res_taken = 0;
  logic [3:0] pred_idx = 0, upd_idx;
  logic pred_ready, upd_valid, upd_taken, mispredict, empty, full, res_err;
  logic [2:0] total_cnt, miss_cnt;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  branch_resolve_queue #(.DEPTH(4), .IDX_W(4), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .pred_valid(pred_valid), .pred_dir(pred_dir), .pred_idx(pred_idx),
    .pred_ready(pred_ready), .res_valid(res_valid), .res_taken(res_taken), .upd_valid(upd_valid),
    .upd_idx(upd_idx), .upd_taken(upd_taken), .mispredict(mispredict), .empty(empty), .full(full),
    .res_err(res_err), .total_cnt(total_cnt), .miss_cnt(miss_cnt));
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic push(input logic d, input logic [3:0] i);
    pred_valid = 1; pred_dir = d; pred_idx = i;
    step();
    pred_valid = 0;
  endtask
  task automatic pop(input logic t);
    res_valid = 1; res_taken = t;
    step();
    res_valid = 0;
  endtask
  initial begin
    step(); step();
    chk("rst_empty", empty, 1); chk("rst_ready", pred_ready, 1); chk("rst_full", full, 0);
    chk("rst_upd_valid", upd_valid, 0); chk("rst_upd_idx", upd_idx, 0); chk("rst_upd_taken", upd_taken, 0);
    chk("rst_miss", mispredict, 0); chk("rst_err", res_err, 0);
    chk("rst_total", total_cnt, 0); chk("rst_miss_cnt", miss_cnt, 0);
    rst = 0;
    push(1, 1); chk("fill1_empty", empty, 0);
    push(0, 2); push(1, 3); push(1, 4);
    chk("fill_full", full, 1); chk("fill_ready", pred_ready, 0);
    push(0, 5); chk("drop_full", full, 1);
    pop(1); chk("r1_valid", upd_valid, 1); chk("r1_idx", upd_idx, 1); chk("r1_taken", upd_taken, 1); chk("r1_miss", mispredict, 0);
    chk("r1_full", full, 0); chk("r1_ready", pred_ready, 1);
    pop(0); chk("r2_idx", upd_idx, 2); chk("r2_taken", upd_taken, 0); chk("r2_miss", mispredict, 0);
    pop(1); chk("r3_idx", upd_idx, 3); chk("r3_miss", mispredict, 0);
    pop(1); chk("r4_idx", upd_idx, 4); chk("r4_miss", mispredict, 0); chk("r4_empty", empty, 1);
    step(); chk("idle_valid", upd_valid, 0); chk("idle_hold_idx", upd_idx, 4);
    chk("t3_total", total_cnt, 4); chk("t3_miss_cnt", miss_cnt, 0);
    push(1, 5); push(1, 6); push(1, 7);
    pred_valid = 1; pred_dir = 1; pred_idx = 8;
    pop(0); pred_valid = 0;
    chk("fl_miss", mispredict, 1); chk("fl_taken", upd_taken, 0); chk("fl_idx", upd_idx, 5);
    chk("fl_empty", empty, 1); chk("fl_miss_cnt", miss_cnt, 1); chk("fl_total", total_cnt, 5);
    step(); chk("fl_pulse", mispredict, 0); chk("fl_lost", empty, 1); chk("fl_ready", pred_ready, 1);
    pop(1); chk("err_set", res_err, 1); chk("err_no_upd", upd_valid, 0); chk("err_total", total_cnt, 5);
    push(0, 9); push(1, 10);
    pred_valid = 1; pred_dir = 1; pred_idx = 11;
    pop(0); pred_valid = 0;
    chk("pp_idx", upd_idx, 9); chk("pp_miss", mispredict, 0); chk("pp_total", total_cnt, 6);
    pop(1); chk("pp2_idx", upd_idx, 10); chk("pp2_empty", empty, 0); chk("pp2_total", total_cnt, 7);
    pop(1); chk("pp3_idx", upd_idx, 11); chk("pp3_empty", empty, 1); chk("sat8_total", total_cnt, 7);
    push(1, 12);
    pop(1); chk("sat9_idx", upd_idx, 12); chk("sat9_total", total_cnt, 7); chk("sat_miss_cnt", miss_cnt, 1);
    chk("err_sticky", res_err, 1);
    push(1, 1); push(1, 2); push(1, 3);
    rst = 1; res_valid = 1; res_taken = 1;
    step(); rst = 0; res_valid = 0;
    chk("mr_valid", upd_valid, 0); chk("mr_empty", empty, 1); chk("mr_total", total_cnt, 0);
    chk("mr_miss_cnt", miss_cnt, 0); chk("mr_err", res_err, 0); chk("mr_idx", upd_idx, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
